// File: rtl/sub16_seq_if.sv
// Start/busy/done bus for the sliced sequential subtractor sub16_seq.
// Optional ovf signal is present only when SUB16_SEQ_OVF_EN is defined.
interface sub16_seq_if #(
    parameter int W = 16
);
    // start is accepted on a rising edge where busy==0; a/b/bi are sampled only on
    // that edge; done pulses for one cycle with d/bo (and ovf) updated in the same cycle.
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         busy;
    logic         done;
    logic [1:0]   fsm_state;
`ifdef SUB16_SEQ_OVF_EN
    logic         ovf;

    modport master (output start, a, b, bi, input d, bo, busy, done, fsm_state, ovf);
    modport slave  (input start, a, b, bi, output d, bo, busy, done, fsm_state, ovf);
`else
    modport master (output start, a, b, bi, input d, bo, busy, done, fsm_state);
    modport slave  (input start, a, b, bi, output d, bo, busy, done, fsm_state);
`endif
endinterface

// File: rtl/sub16_seq.sv
// Multi-cycle borrow-select subtractor: d = a - b - bi, one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow output ovf is enabled by defining SUB16_SEQ_OVF_EN.
module sub16_seq #(
    parameter int W     = 16,
    parameter int SLICE = 4
) (
    input  logic      clk,
    input  logic      rst,
    sub16_seq_if.slave bus
);
    localparam int N  = W / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           load, step;
    logic [W-1:0]   a_q, b_q, acc_q, d_q;
    logic           borrow_q, bo_q;
    logic [CW-1:0]  cnt_q;
    logic           last;
    logic [SLICE:0] cand0, cand1, sel;
    logic [W-1:0]   acc_next;

    // Both borrow-in candidates are formed every cycle; the registered borrow picks one.
    assign last     = (cnt_q == CW'(N - 1));
    assign cand0    = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]};
    assign cand1    = cand0 - (SLICE+1)'(1);
    assign sel      = borrow_q ? cand1 : cand0;
    assign acc_next = W'({sel[SLICE-1:0], acc_q} >> SLICE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SUB16_SEQ_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            cnt_q    <= '0;
`ifdef SUB16_SEQ_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else if (load) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.bi;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef SUB16_SEQ_OVF_EN
            a_msb_q  <= bus.a[W-1];
            b_msb_q  <= bus.b[W-1];
`endif
        end else if (step) begin
            a_q      <= a_q >> SLICE;
            b_q      <= b_q >> SLICE;
            borrow_q <= sel[SLICE];
            acc_q    <= acc_next;
            cnt_q    <= cnt_q + CW'(1);
            // Result registers move only on the final slice, so partial sums never reach d.
            if (last) begin
                d_q  <= acc_next;
                bo_q <= sel[SLICE];
`ifdef SUB16_SEQ_OVF_EN
                ovf_q <= (a_msb_q != b_msb_q) && (acc_next[W-1] != a_msb_q);
`endif
            end
        end
    end

    assign bus.d         = d_q;
    assign bus.bo        = bo_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.fsm_state = state_q;
`ifdef SUB16_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule
